mmio_console: RTL and testbench
===============================

Name: mmio_console

Overview:
- Memory-mapped console/tohost peripheral downstream of rv32i_cpu's data-memory port (MemWrite, MemAddr, MemWData, ByteEnable, MemRData).
- Captures byte stores into a TX FIFO and drains them over a valid/ready byte stream with programmable inter-byte gap.
- Holds the tohost word that ends simulation runs.
- Sits beside data RAM; the top-level mux selects MemRData from this block when sel_hit=1.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base of the 16-byte register window; addr[31:4] must match BASE_ADDR[31:4].
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- GAP_CYCLES, 2, idle cycles forced after each accepted byte; 0 allowed.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- MemWrite  input  1  store strobe from CPU, single cycle
- MemAddr  input  32  byte address from CPU
- MemWData  input  32  lane-aligned store data
- ByteEnable  input  4  byte lanes
- MemRData  output  32  combinational read data for the window
- sel_hit  output  1  MemAddr falls in window (combinational)
- tx_valid  output  1  byte available on tx_data
- tx_data  output  8  byte being offered
- tx_ready  input  1  sink accepts when tx_valid&tx_ready at posedge
- halt  output  1  tohost written with bit0=1
- tohost  output  32  last tohost value

Behaviour:
- Register map (offset = MemAddr[3:2]):
  - 0 TXDATA (W): byte lane selected by ByteEnable (lowest set bit) is pushed.
  - 1 STATUS (R): {27'b0, halt, overflow, busy, full, empty}; write with bit3=1 clears overflow.
  - 2 TOHOST (R/W): write requires ByteEnable=4'b1111, else ignored.
  - 3: reserved, reads 0; or TXCOUNT when the optional feature is compiled in.
- Writes take effect at the posedge where MemWrite=1 and sel_hit=1. Reads are combinational from current state, zero latency, matching the single-cycle CPU.
- Reads outside the window return 32'h0.
- FIFO:
  - count 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - A push when full is dropped and sets overflow (sticky).
  - Exception: push and pop in the same cycle while full is accepted; count stays at FIFO_DEPTH and overflow is not set.
  - Push and pop in the same cycle while empty: push only, no bypass. The byte appears on tx_valid no earlier than the next cycle.
- TX FSM:
  - IDLE: tx_valid=0; move to SEND when FIFO not empty.
  - SEND: tx_valid=1, tx_data=FIFO head. On tx_ready, pop; go to GAP if GAP_CYCLES>0, else stay in SEND when more bytes remain, else IDLE.
  - tx_data must hold stable while tx_valid=1 and tx_ready=0.
  - GAP: counter loads GAP_CYCLES-1 and counts down to 0. At 0, go to SEND if not empty, else IDLE.
  - busy = (state != IDLE).
- Halt:
  - halt is set on a TOHOST write with bit0=1 and cleared only by reset.
  - Once halted, further TOHOST writes are ignored. TXDATA pushes still accepted so the FIFO can drain.
- Reset (asynchronous):
  - state=IDLE, pointers and count=0, gap counter=0, overflow=0, halt=0, tohost=0, tx_valid=0, tx_data=0.
  - Reset mid-transfer discards all FIFO contents.

Optional Feature:
- Macro MMIO_CONSOLE_TXCOUNT_EN.
- Defined: offset 3 reads a 32-bit count of bytes accepted by the sink (tx_valid&tx_ready). It wraps at 2^32, is reset to 0, and a write to offset 3 clears it.
- Undefined: offset 3 reads 0 and writes are ignored; no counter flops.

Test Plan:
- SW 32'h41 to BASE+0 with BE=0001, tx_ready=1, GAP_CYCLES=2 -> tx_valid rises 1 cycle later with tx_data=8'h41. Then 2 cycles with tx_valid=0; STATUS reads 32'h1 afterwards.
- SB 8'h5A at BASE+1 (BE=0010, MemWData=32'h00005A00) -> tx_data=8'h5A.
- tx_ready=0, push 9 bytes with FIFO_DEPTH=8 -> STATUS=32'h0E (overflow, busy, full). Writing 32'h8 to STATUS gives 32'h06. Releasing tx_ready yields exactly the first 8 bytes in order.
- Hold tx_ready=0 for 5 cycles with tx_valid=1 -> tx_data constant; a push in that window does not alter tx_data.
- SW 32'h1 to BASE+8 -> halt=1 next cycle, tohost=32'h1, STATUS bit4=1. A later SW 32'h3 leaves tohost=32'h1. A SH with BE=0011 before halt is ignored.
- Assert reset with 3 bytes queued and tx_valid=1 -> all outputs 0 immediately; after release, no bytes are emitted. With MMIO_CONSOLE_TXCOUNT_EN, offset 3 reads 0.

Source files
------------

// File: rtl/mmio_console.sv
// Memory-mapped console: byte stores feed a TX FIFO drained over valid/ready with a fixed gap; also holds tohost/halt.
// Optional byte-accepted counter at offset 3 is compiled in with MMIO_CONSOLE_TXCOUNT_EN.
module mmio_console #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWData,
  input  logic [3:0]  ByteEnable,
  output logic [31:0] MemRData,
  output logic        sel_hit,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] tohost
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             overflow_q, overflow_d;
  logic             halt_q, halt_d;
  logic [31:0]      tohost_q, tohost_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];

  logic [1:0]  reg_off;
  logic        wr_txdata;
  logic        wr_status;
  logic        wr_tohost;
  logic [7:0]  push_byte;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push_ok;
  logic        push_drop;
  logic        busy;
  logic [31:0] status_word;
  logic        unused_addr_bits;

  assign sel_hit          = (MemAddr[31:4] == BASE_ADDR[31:4]);
  assign reg_off          = MemAddr[3:2];
  assign unused_addr_bits = ^MemAddr[1:0];

  assign wr_txdata = MemWrite && sel_hit && (reg_off == 2'd0) && (ByteEnable != 4'b0000);
  assign wr_status = MemWrite && sel_hit && (reg_off == 2'd1);
  assign wr_tohost = MemWrite && sel_hit && (reg_off == 2'd2);

  // The lowest enabled lane carries the byte; SB/SH/SW all work.
  always_comb begin
    push_byte = MemWData[7:0];
    if (ByteEnable[0])      push_byte = MemWData[7:0];
    else if (ByteEnable[1]) push_byte = MemWData[15:8];
    else if (ByteEnable[2]) push_byte = MemWData[23:16];
    else if (ByteEnable[3]) push_byte = MemWData[31:24];
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign tx_valid   = (state_q == ST_SEND);
  assign tx_data    = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign pop        = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok    = wr_txdata && (!fifo_full || pop);
  assign push_drop  = wr_txdata && fifo_full && !pop;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_byte;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end else if (count_q > CNT_W'(1)) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = fifo_empty ? ST_IDLE : ST_SEND;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    halt_d     = halt_q;
    tohost_d   = tohost_q;
    if (push_drop)                     overflow_d = 1'b1;
    else if (wr_status && MemWData[3]) overflow_d = 1'b0;
    // Once halted, tohost is frozen so the exit code cannot be overwritten.
    if (wr_tohost && (ByteEnable == 4'b1111) && !halt_q) begin
      tohost_d = MemWData;
      halt_d   = MemWData[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      gap_cnt_q  <= '0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
      tohost_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      gap_cnt_q  <= gap_cnt_d;
      overflow_q <= overflow_d;
      halt_q     <= halt_d;
      tohost_q   <= tohost_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef MMIO_CONSOLE_TXCOUNT_EN
  logic [31:0] txcount_q, txcount_d;

  always_comb begin
    txcount_d = txcount_q;
    if (pop) txcount_d = txcount_q + 32'd1;
    if (MemWrite && sel_hit && (reg_off == 2'd3)) txcount_d = 32'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) txcount_q <= 32'h0;
    else       txcount_q <= txcount_d;
  end
`endif

  assign status_word = {27'b0, halt_q, overflow_q, busy, fifo_full, fifo_empty};

  always_comb begin
    MemRData = 32'h0;
    if (sel_hit) begin
      case (reg_off)
        2'd1:    MemRData = status_word;
        2'd2:    MemRData = tohost_q;
`ifdef MMIO_CONSOLE_TXCOUNT_EN
        2'd3:    MemRData = txcount_q;
`endif
        default: MemRData = 32'h0;
      endcase
    end
  end

  assign halt   = halt_q;
  assign tohost = tohost_q;

endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: queue-based reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_mmio_console;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 8;
  localparam int          GAP   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] MemAddr = 32'h0;
  logic [31:0] MemWData = 32'h0;
  logic [3:0]  ByteEnable = 4'h0;
  logic [31:0] MemRData;
  logic        sel_hit;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        halt;
  logic [31:0] tohost;

  mmio_console #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData),
    .ByteEnable(ByteEnable), .MemRData(MemRData), .sel_hit(sel_hit), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .halt(halt), .tohost(tohost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes in flight, last-accept cycle, and the sticky registers.
  logic [7:0]  mq[$];
  logic [7:0]  sink_log[$];
  bit          m_valid;
  bit          m_ovf;
  bit          m_halt;
  logic [31:0] m_tohost;
  logic [31:0] m_txcnt;
  int          cyc;
  int          last_acc;

  function automatic bit in_window(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [3:0] be);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 3; i >= 0; i--) if (be[i]) b = d[8*i +: 8];
    return b;
  endfunction

  function automatic bit m_busy();
    return m_valid || (cyc >= last_acc + 1 && cyc <= last_acc + GAP);
  endfunction

  function automatic logic [31:0] m_status();
    return {27'b0, m_halt, m_ovf, m_busy(), mq.size() == DEPTH, mq.size() == 0};
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    if (!in_window(a)) return 32'h0;
    case (a[3:2])
      2'd1: return m_status();
      2'd2: return m_tohost;
`ifdef MMIO_CONSOLE_TXCOUNT_EN
      2'd3: return m_txcnt;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_halt   = 1'b0;
    m_tohost = 32'h0;
    m_txcnt  = 32'h0;
    cyc      = 0;
    last_acc = -1000;
  endtask

  task automatic model_step();
    int sz;
    bit acc;
    sz  = mq.size();
    acc = m_valid && tx_ready;
    if (acc) begin
      void'(mq.pop_front());
      last_acc = cyc;
      m_txcnt  = m_txcnt + 32'd1;
    end
    if (MemWrite && in_window(MemAddr)) begin
      case (MemAddr[3:2])
        2'd0: if (ByteEnable != 4'h0) begin
          if (sz == DEPTH && !acc) m_ovf = 1'b1;
          else mq.push_back(lane_byte(MemWData, ByteEnable));
        end
        2'd1: if (MemWData[3]) m_ovf = 1'b0;
        2'd2: if (ByteEnable == 4'hF && !m_halt) begin
          m_tohost = MemWData;
          m_halt   = MemWData[0];
        end
        default: m_txcnt = 32'h0;
      endcase
    end
    cyc = cyc + 1;
    // A byte is offered once it was queued before this edge and the gap after the last accept has elapsed.
    m_valid = (sz - int'(acc) > 0) && (cyc >= last_acc + GAP + 1);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("tx_valid", tx_valid, m_valid);
      check("tx_data", tx_data, m_valid ? mq[0] : 8'h00);
      check("sel_hit", sel_hit, in_window(MemAddr));
      check("rdata", MemRData, m_rdata(MemAddr));
      check("halt", halt, m_halt);
      check("tohost", tohost, m_tohost);
      if (tx_valid && tx_ready) sink_log.push_back(tx_data);
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    MemWrite = 1'b1; MemAddr = a; MemWData = d; ByteEnable = be;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MemWrite = 1'b0; MemAddr = 32'h0; MemWData = 32'h0; ByteEnable = 4'h0;
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    MemWrite = 1'b0; MemAddr = a; ByteEnable = 4'h0;
    @(negedge clk);
    check(name, MemRData, exp);
  endtask

  int start;

  initial begin
    @(negedge clk);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_tohost", tohost, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    rd(BASE + 32'h4, 32'h1, "rst_status");

    // Single SW: offered one cycle after it lands, then two gap cycles.
    wr(BASE, 32'h41, 4'b0001);
    idle(1); @(negedge clk); check("t1_not_yet", tx_valid, 1'b0);
    idle(1); @(negedge clk); check("t1_valid", tx_valid, 1'b1); check("t1_data", tx_data, 8'h41);
    idle(1); @(negedge clk); check("t1_gap0", tx_valid, 1'b0);
    idle(1); @(negedge clk); check("t1_gap1", tx_valid, 1'b0);
    rd(BASE + 32'h4, 32'h1, "t1_status");

    // SB on lane 1.
    wr(BASE + 32'h1, 32'h0000_5A00, 4'b0010);
    idle(6);
    check("sb_count", sink_log.size(), 2);
    check("sb_byte", sink_log[sink_log.size() - 1], 8'h5A);

    // Overflow with sink stalled; head must stay put while pushes land.
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(BASE, 32'h10 + i, 4'b0001);
    idle(5);
    @(negedge clk); check("hold_valid", tx_valid, 1'b1); check("hold_data", tx_data, 8'h10);
    rd(BASE + 32'h4, 32'h0E, "ovf_status");
    wr(BASE + 32'h4, 32'h8, 4'b1111);
    rd(BASE + 32'h4, 32'h06, "ovf_cleared");
    start = sink_log.size();
    @(posedge clk); #1 tx_ready = 1'b1;
    idle(30);
    check("drain_count", sink_log.size() - start, 8);
    for (int i = 0; i < 8; i++) check("drain_order", sink_log[start + i], 8'h10 + i);
    rd(BASE + 32'h4, 32'h1, "drain_status");

    // Tohost / halt.
    wr(BASE + 32'h8, 32'h1, 4'b0011);
    rd(BASE + 32'h8, 32'h0, "sh_ignored");
    wr(BASE + 32'h8, 32'h1, 4'b1111);
    idle(1); @(negedge clk); check("halt_set", halt, 1'b1); check("tohost_val", tohost, 32'h1);
    rd(BASE + 32'h4, 32'h11, "halt_status");
    wr(BASE + 32'h8, 32'h3, 4'b1111);
    rd(BASE + 32'h8, 32'h1, "tohost_frozen");
    wr(BASE, 32'h77, 4'b0001);
    idle(5);
    check("post_halt_byte", sink_log[sink_log.size() - 1], 8'h77);

    // Reset mid-transfer.
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(BASE, 32'hA0 + i, 4'b0001);
    idle(3);
    @(negedge clk); check("pre_rst_valid", tx_valid, 1'b1);
    @(posedge clk); #1 reset = 1'b1; MemAddr = 32'h0;
    #1;
    check("arst_valid", tx_valid, 1'b0);
    check("arst_data", tx_data, 8'h00);
    check("arst_halt", halt, 1'b0);
    check("arst_tohost", tohost, 32'h0);
    check("arst_rdata", MemRData, 32'h0);
    @(posedge clk); #1 reset = 1'b0; tx_ready = 1'b1;
    start = sink_log.size();
    idle(10);
    check("rst_no_bytes", sink_log.size() - start, 0);
    rd(BASE + 32'hC, 32'h0, "off3_zero");
    rd(BASE + 32'h4, 32'h1, "post_rst_status");
    rd(BASE - 32'h4, 32'h0, "below_window");
    rd(BASE + 32'h10, 32'h0, "above_window");
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
